// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter load controller.
//   PC_WIDTH    : default program-counter width, matches the reg_6bit store
//   pc_t        : one program-counter value
//   pc_state_e  : sequencer states (INIT, RUN, HALT)
// ---------------------------------------------------------------------------
package pc_pkg;

   localparam int PC_WIDTH = 6;

   typedef logic [PC_WIDTH-1:0] pc_t;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Combinational next-load selection for pc_load_ctrl. Picks between the
// reset-address load, an accepted jump, an increment, or holding, and works
// out which state the sequencer moves to.
// Ports:
//   i_state       : current sequencer state
//   i_run         : increment permitted
//   i_jmp_fire    : jump handshake completes this cycle (valid && ready)
//   i_jmp_addr    : jump target
//   i_pc          : PC value the register holds after any load in flight
//   o_ld_next     : next load strobe
//   o_value_next  : next load value (only meaningful when o_ld_next is high)
//   o_wrap_next   : next wrap pulse
//   o_state_next  : next sequencer state
// ---------------------------------------------------------------------------
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int               WIDTH      = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0,
   parameter logic [WIDTH-1:0] HALT_ADDR  = '1
) (
   input  pc_state_e        i_state,
   input  logic             i_run,
   input  logic             i_jmp_fire,
   input  logic [WIDTH-1:0] i_jmp_addr,
   input  logic [WIDTH-1:0] i_pc,
   output logic             o_ld_next,
   output logic [WIDTH-1:0] o_value_next,
   output logic             o_wrap_next,
   output pc_state_e        o_state_next
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Priority select: jump beats increment beats hold. HALT only reacts to
   // jumps, so run is ignored there. Any load whose value is the halt
   // address parks the sequencer in HALT; every other load lands in RUN,
   // which also covers leaving HALT through a jump.
   always_comb begin
      o_ld_next    = 1'b0;
      o_value_next = '0;
      o_wrap_next  = 1'b0;
      o_state_next = i_state;

      case (i_state)
         INIT: begin
            o_ld_next    = 1'b1;
            o_value_next = RESET_ADDR;
         end
         RUN: begin
            if (i_jmp_fire) begin
               o_ld_next    = 1'b1;
               o_value_next = i_jmp_addr;
            end else if (i_run) begin
               o_ld_next    = 1'b1;
               o_value_next = i_pc + ONE;
               o_wrap_next  = (i_pc == '1);
            end
         end
         HALT: begin
            if (i_jmp_fire) begin
               o_ld_next    = 1'b1;
               o_value_next = i_jmp_addr;
            end
         end
         default: begin
            o_state_next = INIT;
         end
      endcase

      if (o_ld_next) begin
         o_state_next = (o_value_next == HALT_ADDR) ? HALT : RUN;
      end
   end

endmodule

// File: rtl/pc_load_ctrl.sv
// ---------------------------------------------------------------------------
// pc_load_ctrl
// Load-side controller for the program counter. Drives the load strobe and
// load value of the external reg_6bit, sequencing reset initialisation,
// free-running increment with wrap, and handshaked jumps.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : synchronous active-low reset
//   i_run        : level, permits increment steps
//   i_jmp_valid  : jump request valid
//   i_jmp_addr   : jump target
//   o_jmp_ready  : jump accepted when high together with i_jmp_valid
//   o_ld         : registered load strobe to reg_6bit
//   o_l_value    : registered load value to reg_6bit
//   o_pc_shadow  : copy of the value last loaded into reg_6bit
//   o_wrap       : one-cycle pulse on the load that wraps to zero
//   o_halted     : high while parked in HALT
// ---------------------------------------------------------------------------
module pc_load_ctrl
   import pc_pkg::*;
#(
   parameter int               WIDTH      = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0,
   parameter logic [WIDTH-1:0] HALT_ADDR  = '1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_run,
   input  logic             i_jmp_valid,
   input  logic [WIDTH-1:0] i_jmp_addr,
   output logic             o_jmp_ready,
   output logic             o_ld,
   output logic [WIDTH-1:0] o_l_value,
   output logic [WIDTH-1:0] o_pc_shadow,
   output logic             o_wrap,
   output logic             o_halted
);

   pc_state_e        r_state;
   logic             r_ld;
   logic [WIDTH-1:0] r_lValue;
   logic [WIDTH-1:0] r_pcShadow;
   logic             r_wrap;
   logic             r_halted;

   logic             w_jmpFire;
   logic [WIDTH-1:0] w_pcCur;
   logic             w_ldNext;
   logic [WIDTH-1:0] w_valueNext;
   logic             w_wrapNext;
   pc_state_e        w_stateNext;

   // Ready depends on state alone so a requester may wait on it before
   // raising valid without forming a combinational loop.
   assign o_jmp_ready = (r_state != INIT);
   assign w_jmpFire   = i_jmp_valid && o_jmp_ready;

   // The shadow lags a load by one cycle, so increments must start from the
   // value that is being loaded right now, otherwise back-to-back increments
   // would repeat the same value.
   assign w_pcCur = r_ld ? r_lValue : r_pcShadow;

   pc_next_sel #(
      .WIDTH      (WIDTH),
      .RESET_ADDR (RESET_ADDR),
      .HALT_ADDR  (HALT_ADDR)
   ) u_nextSel (
      .i_state      (r_state),
      .i_run        (i_run),
      .i_jmp_fire   (w_jmpFire),
      .i_jmp_addr   (i_jmp_addr),
      .i_pc         (w_pcCur),
      .o_ld_next    (w_ldNext),
      .o_value_next (w_valueNext),
      .o_wrap_next  (w_wrapNext),
      .o_state_next (w_stateNext)
   );

   // State and all outputs are registered here. The load value only changes
   // when a load is issued, so it keeps the last loaded value while holding.
   // The shadow follows each load one edge later, in step with reg_6bit.
   // Halted rises on the first edge spent in HALT without a jump leaving it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= INIT;
         r_ld       <= 1'b0;
         r_lValue   <= '0;
         r_pcShadow <= '0;
         r_wrap     <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_ld    <= w_ldNext;
         r_wrap  <= w_wrapNext;
         if (w_ldNext) begin
            r_lValue <= w_valueNext;
         end
         if (r_ld) begin
            r_pcShadow <= r_lValue;
         end
         r_halted <= (r_state == HALT) && !w_jmpFire;
      end
   end

   assign o_ld        = r_ld;
   assign o_l_value   = r_lValue;
   assign o_pc_shadow = r_pcShadow;
   assign o_wrap      = r_wrap;
   assign o_halted    = r_halted;

endmodule

// File: tb/tb_pc_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_load_ctrl
// Directed bench for pc_load_ctrl. Two instances share the same inputs: one
// with the default halt address 63 and one with halt address 60, so the
// wrap from 63 to 0 can be observed on the second.
// ---------------------------------------------------------------------------
module tb_pc_load_ctrl;

   logic       clk;
   logic       rstN;
   logic       run;
   logic       jmpValid;
   logic [5:0] jmpAddr;

   logic       readyA, ldA, wrapA, haltedA;
   logic [5:0] valueA, shadowA;
   logic       readyB, ldB, wrapB, haltedB;
   logic [5:0] valueB, shadowB;

   int checks;
   int passes;

   pc_load_ctrl dutA (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_run       (run),
      .i_jmp_valid (jmpValid),
      .i_jmp_addr  (jmpAddr),
      .o_jmp_ready (readyA),
      .o_ld        (ldA),
      .o_l_value   (valueA),
      .o_pc_shadow (shadowA),
      .o_wrap      (wrapA),
      .o_halted    (haltedA)
   );

   pc_load_ctrl #(.HALT_ADDR(6'd60)) dutB (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_run       (run),
      .i_jmp_valid (jmpValid),
      .i_jmp_addr  (jmpAddr),
      .o_jmp_ready (readyB),
      .o_ld        (ldB),
      .o_l_value   (valueB),
      .o_pc_shadow (shadowB),
      .o_wrap      (wrapB),
      .o_halted    (haltedB)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Set inputs, advance one rising edge and settle just after it.
   task automatic applyStimulus(input logic r, input logic rn, input logic jv, input logic [5:0] ja);
      rstN     = r;
      run      = rn;
      jmpValid = jv;
      jmpAddr  = ja;
      @(posedge clk);
      #1;
   endtask

   // Main directed sequence; every expected value below is hand-derived.
   initial begin
      checks   = 0;
      passes   = 0;
      rstN     = 1'b0;
      run      = 1'b0;
      jmpValid = 1'b0;
      jmpAddr  = '0;

      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0);
      checkOutput("rst ld",     ldA,     0);
      checkOutput("rst value",  valueA,  0);
      checkOutput("rst shadow", shadowA, 0);
      checkOutput("rst wrap",   wrapA,   0);
      checkOutput("rst halted", haltedA, 0);
      checkOutput("rst ready",  readyA,  0);

      // INIT edge then one idle RUN edge.
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
      checkOutput("init ld",    ldA,    1);
      checkOutput("init value", valueA, 0);
      checkOutput("init ready", readyA, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
      checkOutput("idle ld",     ldA,     0);
      checkOutput("idle value",  valueA,  0);
      checkOutput("idle shadow", shadowA, 0);

      // Five increments, shadow one behind.
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
         checkOutput($sformatf("inc%0d ld", i),     ldA,     1);
         checkOutput($sformatf("inc%0d value", i),  valueA,  i);
         checkOutput($sformatf("inc%0d shadow", i), shadowA, i - 1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
      checkOutput("hold ld",     ldA,     0);
      checkOutput("hold value",  valueA,  5);
      checkOutput("hold shadow", shadowA, 5);

      // Bring the shadow to 4, then jump and run together.
      applyStimulus(1'b1, 1'b0, 1'b1, 6'd4);
      checkOutput("jmp4 value", valueA, 4);
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
      checkOutput("jmp4 shadow", shadowA, 4);
      applyStimulus(1'b1, 1'b1, 1'b1, 6'd10);
      checkOutput("prio ld",    ldA,    1);
      checkOutput("prio value", valueA, 10);
      checkOutput("prio wrap",  wrapA,  0);
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
      checkOutput("prio shadow", shadowA, 10);

      // Jump to 62 then increment: A halts after 63, B wraps to 0.
      applyStimulus(1'b1, 1'b0, 1'b1, 6'd62);
      checkOutput("j62 A value", valueA, 62);
      checkOutput("j62 B value", valueB, 62);
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
      checkOutput("63 A value", valueA, 63);
      checkOutput("63 A ld",    ldA,    1);
      checkOutput("63 B value", valueB, 63);
      checkOutput("63 B wrap",  wrapB,  0);
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
      checkOutput("halt A ld",     ldA,     0);
      checkOutput("halt A halted", haltedA, 1);
      checkOutput("halt A shadow", shadowA, 63);
      checkOutput("wrap B ld",     ldB,     1);
      checkOutput("wrap B value",  valueB,  0);
      checkOutput("wrap B wrap",   wrapB,   1);
      checkOutput("wrap B halted", haltedB, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
      checkOutput("halt A run ld", ldA,     0);
      checkOutput("halt A still",  haltedA, 1);
      checkOutput("halt A value",  valueA,  63);
      checkOutput("halt A ready",  readyA,  1);
      checkOutput("B after wrap",  valueB,  1);
      checkOutput("B wrap low",    wrapB,   0);

      // Jump out of HALT to 7, then resume incrementing.
      applyStimulus(1'b1, 1'b1, 1'b1, 6'd7);
      checkOutput("exit ld",     ldA,     1);
      checkOutput("exit value",  valueA,  7);
      checkOutput("exit halted", haltedA, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
      checkOutput("resume value", valueA, 8);

      // Jump straight onto the halt address re-enters HALT.
      applyStimulus(1'b1, 1'b0, 1'b1, 6'd63);
      checkOutput("j63 value", valueA, 63);
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
      checkOutput("rehalt ld",     ldA,     0);
      checkOutput("rehalt halted", haltedA, 1);

      // Reset while incrementing at 20 with a jump pending.
      applyStimulus(1'b1, 1'b0, 1'b1, 6'd19);
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
      checkOutput("at20 value", valueA, 20);
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd40);
      checkOutput("mid rst ld",     ldA,     0);
      checkOutput("mid rst value",  valueA,  0);
      checkOutput("mid rst shadow", shadowA, 0);
      checkOutput("mid rst ready",  readyA,  0);
      applyStimulus(1'b1, 1'b1, 1'b1, 6'd40);
      checkOutput("reinit ld",    ldA,    1);
      checkOutput("reinit value", valueA, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
      checkOutput("reinit hold ld",  ldA,     0);
      checkOutput("reinit value2",   valueA,  0);
      checkOutput("reinit shadow",   shadowA, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pc_load_ctrl.md
# pc_load_ctrl

Load-side controller for the small program counter. It generates the `ld` strobe and 6-bit load value that drive `reg_6bit`. It sequences reset-address initialisation, free-running increment with wrap-around, and handshaked jump requests. It sits between the control/branch logic and the PC register, so the register stays a plain loadable store.

## Interface

Parameters:
- `WIDTH`, 6: PC width, equal to the `reg_6bit` width.
- `RESET_ADDR`, 0: first address loaded after reset.
- `HALT_ADDR`, 63: address that stops the sequencer once it has been loaded.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `run`, in, 1: level; permits increment steps.
- `jmp_valid`, in, 1: jump request valid.
- `jmp_addr`, in, WIDTH: jump target.
- `jmp_ready`, out, 1: jump request accepted this cycle when high together with `jmp_valid`.
- `ld`, out, 1: load strobe to `reg_6bit`; registered.
- `l_value`, out, WIDTH: load value to `reg_6bit`; registered.
- `pc_shadow`, out, WIDTH: copy of the value last loaded.
- `wrap`, out, 1: one-cycle pulse when an increment wraps from 63 to 0.
- `halted`, out, 1: high while in HALT.

## Operation

- Reset values while `rst_n`=0 at a clock edge:
  - `ld`=0, `l_value`=0, `pc_shadow`=0, `wrap`=0, `halted`=0, `jmp_ready`=0.
  - State goes to INIT.
- States:
  - INIT: for one cycle, `ld`=1 and `l_value`=RESET_ADDR; then go to RUN.
  - RUN: per cycle, priority is jump, then increment, then hold.
    - Jump when `jmp_valid && jmp_ready`: `ld`=1, `l_value`=`jmp_addr`.
    - Increment when `run`=1: `ld`=1, `l_value`=`pc_shadow`+1 mod 2^WIDTH. Assert `wrap` when `pc_shadow`=2^WIDTH-1.
    - Otherwise hold: `ld`=0 and `l_value` keeps its value.
  - HALT: entered the cycle after any load of HALT_ADDR.
    - `ld`=0 and `halted`=1.
    - Increments are ignored.
    - An accepted jump leaves HALT: it loads `jmp_addr` and returns to RUN. If the target is itself HALT_ADDR, re-enter HALT.
- `jmp_ready`:
  - 1 in RUN and HALT, 0 in INIT and during reset.
  - Combinational from state only; it must not depend on `jmp_valid`.
- `pc_shadow` updates to `l_value` on every cycle in which `ld`=1. This keeps it equal to the `reg_6bit` output one cycle after each load.
- Arithmetic: increment is unsigned WIDTH-bit, with the carry discarded into `wrap`.
- Jump and `run` together in RUN: the jump wins, no increment occurs, and `wrap`=0.
- Reset mid-operation (any state): outputs return to reset values on the same edge, then INIT reloads RESET_ADDR. A pending jump is dropped.

## Timing

- All outputs are registered except `jmp_ready`.
- Latency from an accepted jump (edge N) or `run`=1 sampled (edge N):
  - `ld` and `l_value` are valid after edge N.
  - `reg_6bit` captures the value at edge N+1.
  - `pc_shadow` updates at edge N+1.
- After `rst_n` rises, the first edge is INIT, giving `ld`=1 with RESET_ADDR. The next edge is the first RUN decision.
- Sustained `run`=1 gives one load per cycle, throughput 1.
- `wrap` is high for exactly the cycle in which `ld` carries 0 from the wrap.

## Structure

- Shared package `pc_pkg`:
  - `PC_WIDTH`=6.
  - State enum: INIT, RUN, HALT.
  - `pc_t` typedef.
- One sub-module, `pc_next_sel`: combinational next-value and priority select. Inputs are state, `run`, the jump handshake and `pc_shadow`. Outputs are next `ld`, next `l_value`, next `wrap` and next state.
- The top module holds the registers and state. `reg_6bit` is instantiated by the parent, not inside this block.

## Test plan

- Reset then release with `run`=0 → one `ld` pulse with `l_value`=0, then `ld`=0 held; `pc_shadow`=0, `jmp_ready`=1.
- `run`=1 for 5 cycles from 0 → `l_value` 1,2,3,4,5 on consecutive cycles; `pc_shadow` trails by one cycle.
- Jump to 62 then `run`=1 → loads 62 (jump), 63 (increment), then `halted`=1 and `ld`=0. Rerun with HALT_ADDR=60 to get loads 62,63,0 with `wrap`=1 on the 0 load.
- `jmp_valid`=1, `jmp_addr`=10 and `run`=1 in the same cycle with `pc_shadow`=4 → `l_value`=10, not 5; `wrap`=0.
- In HALT, `run`=1 → no `ld`; jump to 7 → `ld`=1, `l_value`=7, back to RUN.
- Assert `rst_n`=0 while incrementing at 20 → next edge all outputs 0; after release, INIT reloads 0 and the pending jump is not taken.
